fetch_unit: RTL and testbench

- Instruction-fetch front end. It owns the architectural fetch PC, issues instruction-memory reads over a valid/ready request channel and collects the responses.
- It delivers {pc, instruction} pairs to decode through a small FIFO.
- It consumes the next-PC redirect that the execute-stage next-PC logic produces for taken branches, jal and jalr; it is the consumer end of that redirect path. A redirect flushes queued and in-flight fetches.

---
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues one imem read at a time,
// and queues {pc, instruction} pairs for decode. Redirects flush queued and in-flight fetches.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {REQ = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_next;
  logic [63:0]   head;
  logic [63:0]   mem [FIFO_DEPTH];
  logic [31:0]   redirect_aligned;
  logic          fifo_space;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic          unused_bits;

  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  assign unused_bits      = ^redirect_pc[1:0];
  assign fifo_space       = (count < CW'(FIFO_DEPTH));
  // Valid is also gated by reset so nothing is requested while reset is held.
  assign imem_req_valid   = !reset && (state == REQ) && fifo_space && !redirect_valid;
  assign imem_req_addr    = {fetch_pc[31:2], 2'b00};
  assign req_fire         = imem_req_valid && imem_req_ready;
  assign push             = (state == WAIT) && imem_resp_valid && !redirect_valid;
  assign inst_valid       = (count != CW'(0));
  assign pop              = inst_valid && inst_ready;
  assign rd_next          = rd_ptr + PW'(1);
  assign inst_pc          = head[63:32];
  assign inst_data        = head[31:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= 32'h0000_0000;
    end else begin
      case (state)
        REQ: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
          end else if (req_fire) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
            state    <= imem_resp_valid ? REQ : DROP;
          end else if (imem_resp_valid) begin
            state <= REQ;
          end
        end
        DROP: begin
          if (redirect_valid) fetch_pc <= redirect_aligned;
          if (imem_resp_valid) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

  // Buffer storage carries no reset; only pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_pc, imem_resp_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= CW'(0);
      rd_ptr <= PW'(0);
      wr_ptr <= PW'(0);
      head   <= 64'h0;
    end else if (redirect_valid) begin
      count  <= CW'(0);
      rd_ptr <= PW'(0);
      wr_ptr <= PW'(0);
      head   <= 64'h0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_next;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Head mirrors the next oldest entry; a push lands in head if the queue is (becoming) empty.
      if (push && ((count == CW'(0)) || ((count == CW'(1)) && pop)))
        head <= {req_pc, imem_resp_data};
      else if (pop)
        head <= (count > CW'(1)) ? mem[rd_next] : 64'h0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small variable-latency instruction memory model.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int          n_checks = 0;
  int          n_errors = 0;
  int          lat;
  logic        pend;
  int          cnt;
  logic [31:0] paddr;
  logic [31:0] req_log [$];
  logic [63:0] pop_log [$];

  fetch_unit #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers addr ^ DEAD_0000 exactly lat cycles after acceptance.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= 1'b0; cnt <= 0; paddr <= 32'h0;
      imem_resp_valid <= 1'b0; imem_resp_data <= 32'h0;
    end else begin
      imem_resp_valid <= 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        if (lat == 1) begin
          imem_resp_valid <= 1'b1;
          imem_resp_data  <= imem_req_addr ^ 32'hDEAD_0000;
        end else begin
          pend <= 1'b1; cnt <= lat - 1; paddr <= imem_req_addr;
        end
      end else if (pend) begin
        if (cnt == 1) begin
          imem_resp_valid <= 1'b1;
          imem_resp_data  <= paddr ^ 32'hDEAD_0000;
          pend <= 1'b0;
        end
        cnt <= cnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (!reset && imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
    if (!reset && inst_valid && inst_ready) pop_log.push_back({inst_pc, inst_data});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    req_log.delete();
    pop_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; imem_req_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = 32'h0; inst_ready = 1'b1; lat = 1;
    cyc(2);
    check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    check("rst_inst_data", inst_data, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);

    // Sequential fetch from RESET_PC with 1-cycle memory.
    reset = 1'b0; clear_logs();
    cyc(5);
    imem_req_ready = 1'b0;
    cyc(3);
    check("t1_nreq", req_log.size(), 32'd3);
    check("t1_req0", req_log[0], 32'h0000_0100);
    check("t1_req1", req_log[1], 32'h0000_0104);
    check("t1_req2", req_log[2], 32'h0000_0108);
    check("t1_npop", pop_log.size(), 32'd3);
    check("t1_pc0", pop_log[0][63:32], 32'h0000_0100);
    check("t1_dat0", pop_log[0][31:0], 32'hDEAD_0100);
    check("t1_pc1", pop_log[1][63:32], 32'h0000_0104);
    check("t1_dat1", pop_log[1][31:0], 32'hDEAD_0104);
    check("t1_pc2", pop_log[2][63:32], 32'h0000_0108);
    check("t1_dat2", pop_log[2][31:0], 32'hDEAD_0108);
    check("t1_empty", {31'h0, inst_valid}, 32'h0);

    // Request held with ready low; redirect in third cycle withdraws it.
    clear_logs();
    for (int i = 0; i < 2; i++) begin
      check("hold_valid", {31'h0, imem_req_valid}, 32'h1);
      check("hold_addr", imem_req_addr, 32'h0000_010C);
      cyc(1);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2003; #1;
    check("hold_redir_valid", {31'h0, imem_req_valid}, 32'h0);
    cyc(1);
    redirect_valid = 1'b0; #1;
    check("hold_new_valid", {31'h0, imem_req_valid}, 32'h1);
    check("hold_new_addr", imem_req_addr, 32'h0000_2000);
    cyc(1);
    check("hold_c4_addr", imem_req_addr, 32'h0000_2000);
    check("hold_nreq", req_log.size(), 32'd0);

    // Decode stalled: two entries fill the queue, then fetch stops.
    inst_ready = 1'b0; imem_req_ready = 1'b1; clear_logs();
    cyc(8);
    check("t2_nreq", req_log.size(), 32'd2);
    check("t2_req0", req_log[0], 32'h0000_2000);
    check("t2_req1", req_log[1], 32'h0000_2004);
    check("t2_head_valid", {31'h0, inst_valid}, 32'h1);
    check("t2_head_pc", inst_pc, 32'h0000_2000);
    check("t2_head_dat", inst_data, 32'hDEAD_2000);
    check("t2_full_no_req", {31'h0, imem_req_valid}, 32'h0);
    inst_ready = 1'b1;
    cyc(1);
    inst_ready = 1'b0; imem_req_ready = 1'b0; #1;
    check("t2_resume_valid", {31'h0, imem_req_valid}, 32'h1);
    check("t2_resume_addr", imem_req_addr, 32'h0000_2008);
    check("t2_head2_pc", inst_pc, 32'h0000_2004);
    check("t2_head2_dat", inst_data, 32'hDEAD_2004);
    inst_ready = 1'b1;
    cyc(2);
    check("t2_npop", pop_log.size(), 32'd2);
    check("t2_pop0", pop_log[0][63:32], 32'h0000_2000);
    check("t2_pop1", pop_log[1][63:32], 32'h0000_2004);
    check("t2_drained", {31'h0, inst_valid}, 32'h0);

    // Redirect during WAIT, response 3 cycles after acceptance is dropped.
    lat = 3; imem_req_ready = 1'b1; clear_logs();
    cyc(1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
    cyc(1);
    redirect_valid = 1'b0;
    cyc(2);
    check("t3_dropped", {31'h0, inst_valid}, 32'h0);
    check("t3_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check("t3_req_addr", imem_req_addr, 32'h0000_2000);
    cyc(1);
    imem_req_ready = 1'b0;
    cyc(5);
    check("t3_nreq", req_log.size(), 32'd2);
    check("t3_req0", req_log[0], 32'h0000_2008);
    check("t3_req1", req_log[1], 32'h0000_2000);
    check("t3_npop", pop_log.size(), 32'd1);
    check("t3_pop_pc", pop_log[0][63:32], 32'h0000_2000);
    check("t3_pop_dat", pop_log[0][31:0], 32'hDEAD_2000);

    // Redirect coincident with the response.
    lat = 2; imem_req_ready = 1'b1; clear_logs();
    begin
      int k = 0;
      while (!imem_resp_valid && k < 10) begin
        @(negedge clk);
        k++;
      end
    end
    check("t4_resp_seen", {31'h0, imem_resp_valid}, 32'h1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_5000;
    cyc(1);
    redirect_valid = 1'b0; imem_req_ready = 1'b0; #1;
    check("t4_no_push", {31'h0, inst_valid}, 32'h0);
    check("t4_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check("t4_req_addr", imem_req_addr, 32'h0000_5000);
    check("t4_nreq", req_log.size(), 32'd1);

    // Two redirects while draining; the last one wins.
    lat = 3; imem_req_ready = 1'b1; clear_logs();
    cyc(1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3000;
    cyc(1);
    redirect_pc = 32'h0000_4000;
    cyc(1);
    redirect_valid = 1'b0;
    cyc(1);
    imem_req_ready = 1'b0; #1;
    check("t4b_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check("t4b_req_addr", imem_req_addr, 32'h0000_4000);
    check("t4b_empty", {31'h0, inst_valid}, 32'h0);
    check("t4b_nreq", req_log.size(), 32'd1);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc(1);
    redirect_valid = 1'b0; lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b0; clear_logs();
    cyc(3);
    imem_req_ready = 1'b0; #1;
    check("t5_nreq", req_log.size(), 32'd2);
    check("t5_req0", req_log[0], 32'hFFFF_FFFC);
    check("t5_req_wrap", req_log[1], 32'h0000_0000);
    check("t5_head_valid", {31'h0, inst_valid}, 32'h1);
    check("t5_head_pc", inst_pc, 32'hFFFF_FFFC);
    check("t5_head_dat", inst_data, 32'h2152_FFFC);

    // Reset while a request is outstanding.
    reset = 1'b1; #1;
    check("t6_inst_valid", {31'h0, inst_valid}, 32'h0);
    check("t6_inst_pc", inst_pc, 32'h0);
    check("t6_inst_data", inst_data, 32'h0);
    check("t6_req_valid", {31'h0, imem_req_valid}, 32'h0);
    cyc(1);
    reset = 1'b0; imem_req_ready = 1'b1; clear_logs(); #1;
    check("t6_restart_valid", {31'h0, imem_req_valid}, 32'h1);
    check("t6_restart_addr", imem_req_addr, 32'h0000_0100);
    cyc(1);
    check("t6_nreq", req_log.size(), 32'd1);
    check("t6_req0", req_log[0], 32'h0000_0100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
